alu_wide_seq: RTL and testbench

//  Initiator/sequencer for the 16-bit combinational ALU: accepts one 32-bit request over valid/ready,

---
 rtl/alu_wide_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_wide_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_seq.sv
// alu_wide_seq
//   Sequences one 32-bit request through a 16-bit combinational ALU in two
//   passes: the low half first, then the high half with the carry out of the
//   low half. The two partial results are merged into one 32-bit response.
//
//   State table
//     IDLE | waiting for a request, req_ready=1, ALU inputs parked
//     LO   | ALU computes the low half; low result, zero flag and carry captured
//     HI   | ALU computes the high half; response assembled at end of cycle
//     DONE | response held with resp_valid=1 until resp_ready
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     req_valid/req_ready      request handshake; req_op, req_sign, req_a, req_b
//     resp_valid/resp_ready    response handshake; resp_data, resp_ofl, resp_zero
//     alu_InA..alu_Oper        drive to the external ALU
//     alu_Out, alu_Ofl, alu_Zero  same-cycle results from the external ALU
module alu_wide_seq #(
  parameter int HALF_W = 16,
  parameter logic [2:0] OPER_ADD = 3'b100,
  parameter logic [2:0] OPER_AND = 3'b101,
  parameter logic [2:0] OPER_XOR = 3'b111
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic                  req_sign,
  input  logic [2*HALF_W-1:0]   req_a,
  input  logic [2*HALF_W-1:0]   req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [2*HALF_W-1:0]   resp_data,
  output logic                  resp_ofl,
  output logic                  resp_zero,
  output logic [HALF_W-1:0]     alu_InA,
  output logic [HALF_W-1:0]     alu_InB,
  output logic                  alu_Cin,
  output logic                  alu_invA,
  output logic                  alu_invB,
  output logic                  alu_sign,
  output logic [2:0]            alu_Oper,
  input  logic [HALF_W-1:0]     alu_Out,
  input  logic                  alu_Ofl,
  input  logic                  alu_Zero
);

  localparam int W = 2 * HALF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic [1:0]        op_reg;
  logic              sign_reg;
  logic [HALF_W-1:0] lo_reg;
  logic              lo_zero_reg;
  logic              carry_reg;

  logic              is_arith;
  logic              is_sub;
  logic [2:0]        op_oper;
  logic              lo_carry;

  assign is_arith = ~op_reg[1];
  assign is_sub   = (op_reg == 2'b01);
  assign op_oper  = is_arith ? OPER_ADD : (op_reg[0] ? OPER_XOR : OPER_AND);

  // Carry out of a + b' + cin, recovered from the 16-bit sum alone: the sum
  // wrapped iff it fell below a, or landed exactly on a with cin set (b'=all ones).
  assign lo_carry = (alu_Out < a_reg[HALF_W-1:0]) |
                    (alu_Cin & (alu_Out == a_reg[HALF_W-1:0]));

  always_comb begin
    alu_InA  = '0;
    alu_InB  = '0;
    alu_Cin  = 1'b0;
    alu_invA = 1'b0;
    alu_invB = 1'b0;
    alu_sign = 1'b0;
    alu_Oper = OPER_ADD;
    case (state)
      LO: begin
        alu_InA  = a_reg[HALF_W-1:0];
        alu_InB  = b_reg[HALF_W-1:0];
        alu_invB = is_sub;
        alu_Cin  = is_sub;
        alu_Oper = op_oper;
      end
      HI: begin
        alu_InA  = a_reg[W-1:HALF_W];
        alu_InB  = b_reg[W-1:HALF_W];
        alu_invB = is_sub;
        alu_Cin  = is_arith & carry_reg;
        alu_sign = sign_reg;
        alu_Oper = op_oper;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_ofl    <= 1'b0;
      resp_zero   <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= 2'b00;
      sign_reg    <= 1'b0;
      lo_reg      <= '0;
      lo_zero_reg <= 1'b0;
      carry_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_reg     <= req_a;
            b_reg     <= req_b;
            op_reg    <= req_op;
            sign_reg  <= req_sign;
            req_ready <= 1'b0;
            state     <= LO;
          end
        end
        LO: begin
          lo_reg      <= alu_Out;
          lo_zero_reg <= alu_Zero;
          carry_reg   <= lo_carry;
          state       <= HI;
        end
        HI: begin
          resp_data  <= {alu_Out, lo_reg};
          resp_ofl   <= is_arith & alu_Ofl;
          resp_zero  <= alu_Zero & lo_zero_reg;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          // Always return through IDLE so a new request is never taken here.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_seq.sv
// tb_alu_wide_seq
//   Directed bench for alu_wide_seq. A behavioural 16-bit ALU closes the loop
//   on the alu_* ports; it reports Ofl as signed overflow when sign=1 and as
//   unsigned carry-out when sign=0, and drives Ofl=1 for logic ops so that the
//   response must mask it.
module tb_alu_wide_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_sign;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_ofl;
  logic        resp_zero;
  logic [15:0] alu_InA;
  logic [15:0] alu_InB;
  logic        alu_Cin;
  logic        alu_invA;
  logic        alu_invB;
  logic        alu_sign;
  logic [2:0]  alu_Oper;
  logic [15:0] alu_Out;
  logic        alu_Ofl;
  logic        alu_Zero;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_wide_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_sign(req_sign), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_ofl(resp_ofl), .resp_zero(resp_zero),
    .alu_InA(alu_InA), .alu_InB(alu_InB), .alu_Cin(alu_Cin),
    .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
    .alu_Oper(alu_Oper), .alu_Out(alu_Out), .alu_Ofl(alu_Ofl),
    .alu_Zero(alu_Zero)
  );

  // Behavioural ALU
  logic [15:0] opa, opb;
  logic [16:0] sum;
  always_comb begin
    opa = alu_invA ? ~alu_InA : alu_InA;
    opb = alu_invB ? ~alu_InB : alu_InB;
    sum = {1'b0, opa} + {1'b0, opb} + {16'd0, alu_Cin};
    alu_Out = 16'd0;
    alu_Ofl = 1'b1;
    case (alu_Oper)
      3'b100: begin
        alu_Out = sum[15:0];
        alu_Ofl = alu_sign ? ((opa[15] == opb[15]) && (sum[15] != opa[15])) : sum[16];
      end
      3'b101: alu_Out = opa & opb;
      3'b111: alu_Out = opa ^ opb;
      default: alu_Out = 16'd0;
    endcase
    alu_Zero = (alu_Out == 16'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with the ALU drive checked on each pass.
  task automatic run_op(input string name, input logic [1:0] op, input logic sign,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] exp_oper, input logic exp_invb,
                        input logic lo_cin, input logic hi_cin,
                        input logic [31:0] exp_data, input logic exp_ofl,
                        input logic exp_zero);
    chk({name, " idle_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_sign = sign; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0; req_a = 32'hDEAD_BEEF; req_b = 32'hDEAD_BEEF;
    // LO
    chk({name, " lo_ready"}, 32'(req_ready), 32'd0);
    chk({name, " lo_ina"}, 32'(alu_InA), 32'(a[15:0]));
    chk({name, " lo_inb"}, 32'(alu_InB), 32'(b[15:0]));
    chk({name, " lo_ctl"}, {26'd0, alu_Oper, alu_invB, alu_Cin, alu_sign},
        {26'd0, exp_oper, exp_invb, lo_cin, 1'b0});
    tick();
    // HI
    chk({name, " hi_valid"}, 32'(resp_valid), 32'd0);
    chk({name, " hi_ina"}, 32'(alu_InA), 32'(a[31:16]));
    chk({name, " hi_ctl"}, {26'd0, alu_Oper, alu_invB, alu_Cin, alu_sign},
        {26'd0, exp_oper, exp_invb, hi_cin, sign});
    tick();
    // DONE
    chk({name, " valid"}, 32'(resp_valid), 32'd1);
    chk({name, " data"}, resp_data, exp_data);
    chk({name, " ofl"}, 32'(resp_ofl), 32'(exp_ofl));
    chk({name, " zero"}, 32'(resp_zero), 32'(exp_zero));
    chk({name, " done_park"}, {13'd0, alu_Oper, alu_InA}, {13'd0, 3'b100, 16'd0});
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({name, " back_idle"}, {30'd0, req_ready, resp_valid}, {30'd0, 1'b1, 1'b0});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_sign = 1'b0;
    req_a = '0; req_b = '0; resp_ready = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_flags", {30'd0, resp_ofl, resp_zero}, 32'd0);
    chk("rst_alu", {10'd0, alu_Oper, alu_Cin, alu_invA, alu_invB, alu_InA}, {10'd0, 3'b100, 3'b000, 16'd0});
    rst = 1'b0;
    tick();

    // carry from low half into high half
    run_op("add_carry", 2'b00, 1'b0, 32'h0000_FFFF, 32'h0000_0001,
           3'b100, 1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0);
    // borrow: low pass produces no carry; signed Ofl reading
    run_op("sub_borrow", 2'b01, 1'b1, 32'h0001_0000, 32'h0000_0001,
           3'b100, 1'b1, 1'b1, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0);
    run_op("add_ovf_s", 2'b00, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001,
           3'b100, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0);
    run_op("add_ovf_u", 2'b00, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001,
           3'b100, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
    // logic ops: Cin forced low on HI, Ofl masked
    run_op("xor_zero", 2'b11, 1'b0, 32'h1234_5678, 32'h1234_5678,
           3'b111, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    run_op("and", 2'b10, 1'b0, 32'hF0F0_FFFF, 32'h0FF0_000F,
           3'b101, 1'b0, 1'b0, 1'b0, 32'h00F0_000F, 1'b0, 1'b0);
    // 5-5: low carry out = 1 feeds high pass, full zero result
    run_op("sub_zero", 2'b01, 1'b1, 32'h0000_0005, 32'h0000_0005,
           3'b100, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1);

    // Back-pressure in DONE while a new request is waiting
    req_valid = 1'b1; req_op = 2'b00; req_sign = 1'b0;
    req_a = 32'd1; req_b = 32'd2;
    tick();
    req_a = 32'd10; req_b = 32'd20;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_data", resp_data, 32'd3);
      chk("stall_ready", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("stall_idle", {30'd0, req_ready, resp_valid}, {30'd0, 1'b1, 1'b0});
    chk("stall_ina_idle", 32'(alu_InA), 32'd0);
    chk("stall_retain", resp_data, 32'd3);
    tick();
    req_valid = 1'b0;
    chk("stall_accept", 32'(alu_InA), 32'd10);
    tick();
    tick();
    chk("stall_next", resp_data, 32'd30);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Reset during HI abandons the operation
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'h0000_00AA; req_b = 32'h0000_0011;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_alu", 32'(alu_InA), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_quiet", 32'(resp_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
